// File: rtl/ls_writeback_queue.sv
// Small FIFO that holds load/store writeback results until the writeback mux
// has a cycle in which the FX unit does not claim the shared slot.
module ls_writeback_queue #(
    parameter int addressSize   = 64,
    parameter int regWidth      = 5,
    parameter int queueDepth    = 4,
    parameter int queuePtrWidth = 2
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     LSValid_i,
    input  logic                     LSReg1WritebackEnable_i,
    input  logic                     LSReg2WritebackEnable_i,
    input  logic [regWidth-1:0]      LSReg1WritebackAddress_i,
    input  logic [regWidth-1:0]      LSReg2WritebackAddress_i,
    input  logic [addressSize-1:0]   LSReg1WritebackValue_i,
    input  logic [addressSize-1:0]   LSReg2WritebackValue_i,
    output logic                     LSReady_o,
    input  logic                     FXClaim_i,
    output logic [2:0]               LSFunctionalUnitCode_o,
    output logic                     LSReg1WritebackEnable_o,
    output logic                     LSReg2WritebackEnable_o,
    output logic [regWidth-1:0]      LSReg1WritebackAddress_o,
    output logic [regWidth-1:0]      LSReg2WritebackAddress_o,
    output logic [addressSize-1:0]   LSReg1WritebackValue_o,
    output logic [addressSize-1:0]   LSReg2WritebackValue_o,
    output logic                     overflow_o,
    output logic [queuePtrWidth:0]   count_o
);

    typedef struct packed {
        logic                   en1;
        logic                   en2;
        logic [regWidth-1:0]    addr1;
        logic [regWidth-1:0]    addr2;
        logic [addressSize-1:0] val1;
        logic [addressSize-1:0] val2;
    } entry_t;

    localparam logic [queuePtrWidth:0]   DEPTH_C   = (queuePtrWidth+1)'(queueDepth);
    localparam logic [queuePtrWidth:0]   CNT_ONE   = (queuePtrWidth+1)'(1);
    localparam logic [queuePtrWidth-1:0] PTR_ONE   = queuePtrWidth'(1);

    entry_t                   mem_q [queueDepth];
    logic [queuePtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [queuePtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [queuePtrWidth:0]   count_q, count_d;
    logic                     overflow_q, overflow_d;

    entry_t wr_entry;
    entry_t head;
    logic   has_data, ready, any_en, push, pop, drop;

    assign wr_entry = '{en1:   LSReg1WritebackEnable_i,
                        en2:   LSReg2WritebackEnable_i,
                        addr1: LSReg1WritebackAddress_i,
                        addr2: LSReg2WritebackAddress_i,
                        val1:  LSReg1WritebackValue_i,
                        val2:  LSReg2WritebackValue_i};

    always_comb begin
        has_data   = (count_q != '0);
        ready      = (count_q < DEPTH_C);
        any_en     = LSReg1WritebackEnable_i | LSReg2WritebackEnable_i;
        push       = LSValid_i & ready & any_en;
        drop       = LSValid_i & ~ready & any_en;
        pop        = has_data & ~FXClaim_i;
        overflow_d = overflow_q | drop;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: pointers and count decide what is valid.
    always_ff @(posedge clock_i) begin
        if (push && !flush_i && !reset_i)
            mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        LSFunctionalUnitCode_o   = 3'd0;
        LSReg1WritebackEnable_o  = 1'b0;
        LSReg2WritebackEnable_o  = 1'b0;
        LSReg1WritebackAddress_o = '0;
        LSReg2WritebackAddress_o = '0;
        LSReg1WritebackValue_o   = '0;
        LSReg2WritebackValue_o   = '0;
        if (has_data) begin
            LSFunctionalUnitCode_o   = 3'd1;
            LSReg1WritebackEnable_o  = head.en1;
            LSReg2WritebackEnable_o  = head.en2;
            LSReg1WritebackAddress_o = head.addr1;
            LSReg2WritebackAddress_o = head.addr2;
            LSReg1WritebackValue_o   = head.val1;
            LSReg2WritebackValue_o   = head.val2;
        end
    end

    assign LSReady_o  = ready;
    assign overflow_o = overflow_q;
    assign count_o    = count_q;

endmodule

// File: tb/tb_ls_writeback_queue.sv
// Directed bench for the LS writeback queue: a vector table of per-cycle
// stimulus with hand-computed pre-edge outputs, plus a pointer-wrap stream.
module tb_ls_writeback_queue;

    logic        clk = 1'b0;
    logic        reset_i, flush_i, LSValid_i, FXClaim_i;
    logic        en1_i, en2_i;
    logic [4:0]  a1_i, a2_i;
    logic [63:0] v1_i, v2_i;
    logic        ready_o, en1_o, en2_o, ovf_o;
    logic [2:0]  code_o;
    logic [4:0]  a1_o, a2_o;
    logic [63:0] v1_o, v2_o;
    logic [2:0]  count_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ls_writeback_queue dut (
        .clock_i                 (clk),
        .reset_i                 (reset_i),
        .flush_i                 (flush_i),
        .LSValid_i               (LSValid_i),
        .LSReg1WritebackEnable_i (en1_i),
        .LSReg2WritebackEnable_i (en2_i),
        .LSReg1WritebackAddress_i(a1_i),
        .LSReg2WritebackAddress_i(a2_i),
        .LSReg1WritebackValue_i  (v1_i),
        .LSReg2WritebackValue_i  (v2_i),
        .LSReady_o               (ready_o),
        .FXClaim_i               (FXClaim_i),
        .LSFunctionalUnitCode_o  (code_o),
        .LSReg1WritebackEnable_o (en1_o),
        .LSReg2WritebackEnable_o (en2_o),
        .LSReg1WritebackAddress_o(a1_o),
        .LSReg2WritebackAddress_o(a2_o),
        .LSReg1WritebackValue_o  (v1_o),
        .LSReg2WritebackValue_o  (v2_o),
        .overflow_o              (ovf_o),
        .count_o                 (count_o)
    );

    typedef struct {
        logic        rst, fl, vld, e1, e2, clm;
        logic [4:0]  a1;
        logic [63:0] v1;
        logic        x_rdy, x_e1, x_e2, x_ovf;
        logic [2:0]  x_code, x_cnt;
        logic [4:0]  x_a1;
        logic [63:0] x_v1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic fl, logic vld, logic e1, logic e2,
                                logic [4:0] a1, logic [63:0] v1, logic clm,
                                logic x_rdy, logic [2:0] x_code, logic x_e1, logic x_e2,
                                logic [4:0] x_a1, logic [63:0] x_v1, logic x_ovf,
                                logic [2:0] x_cnt);
        vec_t v;
        v.rst = rst; v.fl = fl; v.vld = vld; v.e1 = e1; v.e2 = e2; v.clm = clm;
        v.a1 = a1; v.v1 = v1;
        v.x_rdy = x_rdy; v.x_code = x_code; v.x_e1 = x_e1; v.x_e2 = x_e2;
        v.x_a1 = x_a1; v.x_v1 = x_v1; v.x_ovf = x_ovf; v.x_cnt = x_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic fl, input logic vld, input logic e1,
                         input logic e2, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [63:0] v1, input logic [63:0] v2, input logic clm);
        reset_i = rst; flush_i = fl; LSValid_i = vld; en1_i = e1; en2_i = e2;
        a1_i = a1; a2_i = a2; v1_i = v1; v2_i = v2; FXClaim_i = clm;
    endtask

    initial begin
        //          rst fl vld e1 e2 a1     v1        clm | rdy code e1 e2 a1     v1        ovf cnt
        // single push, one-cycle presentation
        vecs.push_back(mk(0,0,0,0,0, 5'd0,  64'h0,  0,  1,3'd0,0,0, 5'd0,  64'h0,  0,3'd0));
        vecs.push_back(mk(0,0,1,1,0, 5'd5,  64'hAA, 0,  1,3'd0,0,0, 5'd0,  64'h0,  0,3'd0));
        vecs.push_back(mk(0,0,0,0,0, 5'd0,  64'h0,  0,  1,3'd1,1,0, 5'd5,  64'hAA, 0,3'd1));
        vecs.push_back(mk(0,0,0,0,0, 5'd0,  64'h0,  0,  1,3'd0,0,0, 5'd0,  64'h0,  0,3'd0));
        // FX claim holds head for three cycles
        vecs.push_back(mk(0,0,1,1,0, 5'd1,  64'h11, 1,  1,3'd0,0,0, 5'd0,  64'h0,  0,3'd0));
        vecs.push_back(mk(0,0,1,1,0, 5'd2,  64'h22, 1,  1,3'd1,1,0, 5'd1,  64'h11, 0,3'd1));
        vecs.push_back(mk(0,0,0,0,0, 5'd0,  64'h0,  1,  1,3'd1,1,0, 5'd1,  64'h11, 0,3'd2));
        vecs.push_back(mk(0,0,0,0,0, 5'd0,  64'h0,  1,  1,3'd1,1,0, 5'd1,  64'h11, 0,3'd2));
        vecs.push_back(mk(0,0,0,0,0, 5'd0,  64'h0,  0,  1,3'd1,1,0, 5'd1,  64'h11, 0,3'd2));
        vecs.push_back(mk(0,0,0,0,0, 5'd0,  64'h0,  0,  1,3'd1,1,0, 5'd2,  64'h22, 0,3'd1));
        vecs.push_back(mk(0,0,0,0,0, 5'd0,  64'h0,  0,  1,3'd0,0,0, 5'd0,  64'h0,  0,3'd0));
        // fill under claim, fifth push overflows
        vecs.push_back(mk(0,0,1,1,0, 5'd10, 64'h100,1,  1,3'd0,0,0, 5'd0,  64'h0,  0,3'd0));
        vecs.push_back(mk(0,0,1,1,0, 5'd11, 64'h101,1,  1,3'd1,1,0, 5'd10, 64'h100,0,3'd1));
        vecs.push_back(mk(0,0,1,1,0, 5'd12, 64'h102,1,  1,3'd1,1,0, 5'd10, 64'h100,0,3'd2));
        vecs.push_back(mk(0,0,1,0,1, 5'd13, 64'h103,1,  1,3'd1,1,0, 5'd10, 64'h100,0,3'd3));
        vecs.push_back(mk(0,0,1,1,0, 5'd14, 64'h104,1,  0,3'd1,1,0, 5'd10, 64'h100,0,3'd4));
        vecs.push_back(mk(0,0,0,0,0, 5'd0,  64'h0,  1,  0,3'd1,1,0, 5'd10, 64'h100,1,3'd4));
        // full with pop: push rejected, then accepted the next cycle
        vecs.push_back(mk(0,0,1,1,0, 5'd15, 64'h105,0,  0,3'd1,1,0, 5'd10, 64'h100,1,3'd4));
        vecs.push_back(mk(0,0,1,1,0, 5'd16, 64'h106,0,  1,3'd1,1,0, 5'd11, 64'h101,1,3'd3));
        vecs.push_back(mk(0,0,0,0,0, 5'd0,  64'h0,  0,  1,3'd1,1,0, 5'd12, 64'h102,1,3'd3));
        vecs.push_back(mk(0,0,0,0,0, 5'd0,  64'h0,  0,  1,3'd1,0,1, 5'd13, 64'h103,1,3'd2));
        vecs.push_back(mk(0,0,0,0,0, 5'd0,  64'h0,  0,  1,3'd1,1,0, 5'd16, 64'h106,1,3'd1));
        vecs.push_back(mk(0,0,0,0,0, 5'd0,  64'h0,  0,  1,3'd0,0,0, 5'd0,  64'h0,  1,3'd0));
        // reset clears the sticky overflow
        vecs.push_back(mk(1,0,0,0,0, 5'd0,  64'h0,  0,  1,3'd0,0,0, 5'd0,  64'h0,  1,3'd0));
        vecs.push_back(mk(0,0,0,0,0, 5'd0,  64'h0,  0,  1,3'd0,0,0, 5'd0,  64'h0,  0,3'd0));
        // empty result is discarded
        vecs.push_back(mk(0,0,1,0,0, 5'd7,  64'h77, 0,  1,3'd0,0,0, 5'd0,  64'h0,  0,3'd0));
        vecs.push_back(mk(0,0,0,0,0, 5'd0,  64'h0,  0,  1,3'd0,0,0, 5'd0,  64'h0,  0,3'd0));
        // flush with three queued and a same-cycle push
        vecs.push_back(mk(0,0,1,1,0, 5'd20, 64'h200,1,  1,3'd0,0,0, 5'd0,  64'h0,  0,3'd0));
        vecs.push_back(mk(0,0,1,1,0, 5'd21, 64'h201,1,  1,3'd1,1,0, 5'd20, 64'h200,0,3'd1));
        vecs.push_back(mk(0,0,1,1,0, 5'd22, 64'h202,1,  1,3'd1,1,0, 5'd20, 64'h200,0,3'd2));
        vecs.push_back(mk(0,1,1,1,0, 5'd23, 64'h203,0,  1,3'd1,1,0, 5'd20, 64'h200,0,3'd3));
        vecs.push_back(mk(0,0,0,0,0, 5'd0,  64'h0,  0,  1,3'd0,0,0, 5'd0,  64'h0,  0,3'd0));

        drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 64'h0, 64'h0, 0);
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            @(negedge clk);
            drive(v.rst, v.fl, v.vld, v.e1, v.e2, v.a1, v.a1 + 5'd1, v.v1, ~v.v1, v.clm);
            #1;
            $display("vec %0d: rst=%0d fl=%0d vld=%0d en=%0d%0d a1=%0d clm=%0d -> code=%0d cnt=%0d rdy=%0d ovf=%0d a1_o=%0d",
                     i, v.rst, v.fl, v.vld, v.e1, v.e2, v.a1, v.clm, code_o, count_o, ready_o, ovf_o, a1_o);
            chk($sformatf("v%0d code", i),  64'(code_o),  64'(v.x_code));
            chk($sformatf("v%0d count", i), 64'(count_o), 64'(v.x_cnt));
            chk($sformatf("v%0d ready", i), 64'(ready_o), 64'(v.x_rdy));
            chk($sformatf("v%0d ovf", i),   64'(ovf_o),   64'(v.x_ovf));
            chk($sformatf("v%0d en1", i),   64'(en1_o),   64'(v.x_e1));
            chk($sformatf("v%0d en2", i),   64'(en2_o),   64'(v.x_e2));
            if (v.x_code == 3'd1) begin
                chk($sformatf("v%0d addr1", i), 64'(a1_o), 64'(v.x_a1));
                chk($sformatf("v%0d addr2", i), 64'(a2_o), 64'(v.x_a1 + 5'd1));
                chk($sformatf("v%0d val1", i),  v1_o,      v.x_v1);
                chk($sformatf("v%0d val2", i),  v2_o,      ~v.x_v1);
            end
        end

        // Continuous push/pop stream: pointers wrap twice, order preserved.
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k < 10)
                drive(0, 0, 1, 1'b1, k[0], 5'(k + 3), 5'(k + 17), 64'h1000 + 64'(k),
                      {32'hDEAD_BEEF, 32'(k)}, 0);
            else
                drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 64'h0, 64'h0, 0);
            #1;
            $display("wrap %0d: code=%0d cnt=%0d a1_o=%0d v1_o=0x%0h", k, code_o, count_o, a1_o, v1_o);
            chk($sformatf("w%0d ready", k), 64'(ready_o), 64'd1);
            if (k == 0) begin
                chk("w0 code",  64'(code_o),  64'd0);
                chk("w0 count", 64'(count_o), 64'd0);
            end else begin
                chk($sformatf("w%0d code", k),  64'(code_o),  64'd1);
                chk($sformatf("w%0d count", k), 64'(count_o), 64'd1);
                chk($sformatf("w%0d en1", k),   64'(en1_o),   64'd1);
                chk($sformatf("w%0d en2", k),   64'(en2_o),   64'((k - 1) % 2));
                chk($sformatf("w%0d addr1", k), 64'(a1_o),    64'(k + 2));
                chk($sformatf("w%0d addr2", k), 64'(a2_o),    64'(k + 16));
                chk($sformatf("w%0d val1", k),  v1_o,         64'h1000 + 64'(k - 1));
                chk($sformatf("w%0d val2", k),  v2_o,         {32'hDEAD_BEEF, 32'(k - 1)});
            end
        end
        @(negedge clk);
        #1;
        $display("wrap end: code=%0d cnt=%0d ovf=%0d", code_o, count_o, ovf_o);
        chk("wend code",  64'(code_o),  64'd0);
        chk("wend count", 64'(count_o), 64'd0);
        chk("wend ovf",   64'(ovf_o),   64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
